// File: rtl/donkey_pkg.sv
// Shared game constants for the Kong / barrel logic.
package donkey_pkg;

  localparam int unsigned BARREL_PERIOD      = 90;
  localparam int unsigned KONG_WINDUP_CYCLES = 24;
  localparam logic [15:0] BARREL_LFSR_SEED   = 16'hACE1;

  // HUD counters stick at full scale instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/barrel_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) used to jitter barrel cooldowns.
module barrel_lfsr
  import donkey_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] value_o
);

  logic [15:0] lfsr_q, lfsr_d;
  logic        feedback;

  always_comb begin
    feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    lfsr_d   = {lfsr_q[14:0], feedback};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= BARREL_LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value_o = lfsr_q;

endmodule

// File: rtl/barrel_launcher.sv
// Kong-side barrel initiator: windup, release into the lowest free mover slot, then cooldown.
// Tracks in-flight movers from their done pulses; all outputs are registered.
module barrel_launcher
  import donkey_pkg::*;
#(
  parameter int unsigned SLOTS         = 4,
  parameter int unsigned WINDUP_CYCLES = KONG_WINDUP_CYCLES,
  parameter int unsigned BASE_PERIOD   = BARREL_PERIOD,
  parameter int unsigned JITTER_BITS   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic [SLOTS-1:0] done_i,
  output logic [SLOTS-1:0] barrel_o,
  output logic             kong_throw_o,
  output logic             all_busy_o,
  output logic [7:0]       launched_cnt_o
);

  localparam int unsigned WcntW      = $clog2(WINDUP_CYCLES + 1);
  localparam int unsigned CcntMax    = BASE_PERIOD + (1 << JITTER_BITS) - 1;
  localparam int unsigned CcntW      = (CcntMax < 1) ? 1 : $clog2(CcntMax + 1);
  localparam logic [15:0] JitterMask = 16'((1 << JITTER_BITS) - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWindup,
    StRelease,
    StCooldown
  } state_e;

  state_e           state_q;
  logic [WcntW-1:0] wcnt_q;
  logic [CcntW-1:0] ccnt_q;
  logic [SLOTS-1:0] busy_q, busy_d;
  logic [SLOTS-1:0] barrel_q;
  logic             kong_q;
  logic             all_busy_q;
  logic [7:0]       cnt_q;

  logic [15:0]      lfsr_value;
  logic [SLOTS-1:0] free_onehot;
  logic             free_any;
  logic             launch;

  barrel_lfsr u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .value_o (lfsr_value)
  );

  // Slot choice looks only at registered busy, so a mover that just finished
  // is never restarted before it has cleared its own state.
  always_comb begin
    free_onehot = '0;
    free_any    = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (!busy_q[i] && !free_any) begin
        free_onehot[i] = 1'b1;
        free_any       = 1'b1;
      end
    end
  end

  always_comb begin
    launch = (state_q == StRelease) && free_any;
    busy_d = (busy_q & ~done_i) | (launch ? free_onehot : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      wcnt_q     <= '0;
      ccnt_q     <= '0;
      busy_q     <= '0;
      barrel_q   <= '0;
      kong_q     <= 1'b0;
      all_busy_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      barrel_q   <= '0;
      busy_q     <= busy_d;
      all_busy_q <= &busy_d;
      unique case (state_q)
        StIdle: begin
          if (enable_i && free_any) begin
            state_q <= StWindup;
            wcnt_q  <= '0;
            kong_q  <= 1'b1;
          end
        end
        StWindup: begin
          if (!enable_i) begin
            state_q <= StIdle;
            kong_q  <= 1'b0;
          end else if (wcnt_q == WcntW'(WINDUP_CYCLES - 1)) begin
            state_q <= StRelease;
            kong_q  <= 1'b0;
          end else begin
            wcnt_q <= wcnt_q + WcntW'(1);
          end
        end
        StRelease: begin
          if (launch) begin
            barrel_q <= free_onehot;
            cnt_q    <= sat_inc8(cnt_q);
          end
          state_q <= StCooldown;
          ccnt_q  <= CcntW'(BASE_PERIOD) + CcntW'(lfsr_value & JitterMask);
        end
        StCooldown: begin
          // Cooldown always runs out, even if the game pauses meanwhile.
          if (ccnt_q == '0) begin
            state_q <= StIdle;
          end else begin
            ccnt_q <= ccnt_q - CcntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign barrel_o       = barrel_q;
  assign kong_throw_o   = kong_q;
  assign all_busy_o     = all_busy_q;
  assign launched_cnt_o = cnt_q;

endmodule
